// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: bus between decode/issue + writeback and the register file
// with busy scoreboard.
//
// Parameters
//   DATA_W  register width
//   DEPTH   number of registers (power of two, >= 2)
//   NUM_RD  number of read ports (1..4)
//
// Signals (direction given from the master side)
//   we, wa, wd      out  writeback enable / address / data
//   ra              out  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   alloc_en        out  mark alloc_addr busy (destination issued)
//   alloc_addr      out  register to mark busy
//   flush           out  clear every busy bit
//   rd              in   packed read data, port k at [k*DATA_W +: DATA_W]
//   rbusy           in   bit k = busy bit of register ra[k]
//   pending_cnt     in   number of busy registers
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                     we;
  logic [ADDR_W-1:0]        wa;
  logic [DATA_W-1:0]        wd;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD-1:0]        rbusy;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic                     flush;
  logic [CNT_W-1:0]         pending_cnt;

  modport master (
    output we, wa, wd, ra, alloc_en, alloc_addr, flush,
    input  rd, rbusy, pending_cnt
  );

  modport slave (
    input  we, wa, wd, ra, alloc_en, alloc_addr, flush,
    output rd, rbusy, pending_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised multi-read-port register file with a per-register
// busy scoreboard. Issue allocates a destination (marks it busy), writeback
// stores data and clears the busy bit, flush squashes every busy bit.
//
// Ports
//   clk   in  rising-edge clock for all state
//   rst   in  asynchronous active-high reset (registers, busy bits, count)
//   bus   reg_file_sb_if.slave
//           we/wa/wd        writeback port
//           ra -> rd/rbusy  NUM_RD combinational read ports
//           alloc_en/addr   scoreboard allocate
//           flush           scoreboard squash
//           pending_cnt     registered popcount of the busy bits
//
// Parameters
//   DATA_W, DEPTH, ADDR_W (derived), NUM_RD, ZERO_REG (reg 0 hardwired to 0,
//   never written, never busy)
//
// Build option
//   REG_FILE_SB_BYPASS_EN  when defined, a same-cycle write to the address a
//                          read port is looking at is forwarded to that port
//                          (data and busy). When undefined, reads come purely
//                          from registered state.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  logic wr_ok;
  logic al_ok;
  logic cnt_inc;
  logic cnt_dec;

  // Register 0 is invisible to writes and allocates when hardwired to zero.
  assign wr_ok = bus.we       && !(ZR && (bus.wa == '0));
  assign al_ok = bus.alloc_en && !(ZR && (bus.alloc_addr == '0));

  // Counter deltas are derived from the current busy state so the count tracks
  // the popcount exactly: an alloc only adds when the target was idle, and a
  // write only removes when it clears a busy bit that is not being re-allocated
  // in the same cycle.
  assign cnt_inc = al_ok && !busy[bus.alloc_addr];
  assign cnt_dec = wr_ok &&  busy[bus.wa] && !(al_ok && (bus.alloc_addr == bus.wa));

  // ---- data storage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  // Scoreboard next state: flush dominates everything; otherwise alloc is
  // applied after the writeback clear so a new producer wins on a tie.
  always_comb begin
    busy_nxt = busy;
    if (bus.flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_ok) begin
        busy_nxt[bus.wa] = 1'b0;
      end
      if (al_ok) begin
        busy_nxt[bus.alloc_addr] = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (bus.flush) begin
      cnt_nxt = '0;
    end else if (cnt_inc && !cnt_dec) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else if (cnt_dec && !cnt_inc) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  // ---- scoreboard state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_nxt;
      cnt  <= cnt_nxt;
    end
  end

  assign bus.pending_cnt = cnt;

  // ---- combinational read ports ----
  logic [NUM_RD*DATA_W-1:0] rd_all;
  logic [NUM_RD-1:0]        rbusy_all;

  always_comb begin
    rd_all    = '0;
    rbusy_all = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [ADDR_W-1:0] ra_k;
      ra_k = bus.ra[k*ADDR_W +: ADDR_W];
      rd_all[k*DATA_W +: DATA_W] = regs[ra_k];
      rbusy_all[k]               = busy[ra_k];
`ifdef REG_FILE_SB_BYPASS_EN
      // Forward the in-flight writeback. The forwarded busy reflects what the
      // scoreboard will hold after the edge: set only by a surviving alloc.
      if (!rst && wr_ok && (bus.wa == ra_k)) begin
        rd_all[k*DATA_W +: DATA_W] = bus.wd;
        rbusy_all[k] = bus.alloc_en && (bus.alloc_addr == bus.wa) && !bus.flush;
      end
`endif
    end
  end

  assign bus.rd    = rd_all;
  assign bus.rbusy = rbusy_all;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  reg_file_sb_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus ();

  reg_file_sb #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setra(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    bus.ra = {a1, a0};
  endtask

  // Advance one clock, then drop all one-shot controls away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
    bus.we       = 1'b0;
    bus.alloc_en = 1'b0;
    bus.flush    = 1'b0;
  endtask

  initial begin
    logic [31:0] e;
    rst            = 1'b1;
    bus.we         = 1'b0;
    bus.wa         = '0;
    bus.wd         = '0;
    bus.alloc_en   = 1'b0;
    bus.alloc_addr = '0;
    bus.flush      = 1'b0;
    setra(5'd0, 5'd0);

    // Reset state
    #2;
    chk("rst_rd", bus.rd, 64'h0);
    chk("rst_rbusy", bus.rbusy, 2'b00);
    chk("rst_cnt", bus.pending_cnt, 6'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Some state, then reset mid-cycle
    bus.we = 1'b1; bus.wa = 5'd1; bus.wd = 32'h0000_1234;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd2;
    step();
    setra(5'd1, 5'd2);
    #1;
    chk("pre_rst_rd0", bus.rd[31:0], 32'h0000_1234);
    chk("pre_rst_rbusy", bus.rbusy, 2'b10);
    chk("pre_rst_cnt", bus.pending_cnt, 6'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rd", bus.rd, 64'h0);
    chk("midrst_rbusy", bus.rbusy, 2'b00);
    chk("midrst_cnt", bus.pending_cnt, 6'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero register: write + alloc of reg 0 are ignored
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hDEAD_BEEF;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd0;
    step();
    setra(5'd0, 5'd0);
    #1;
    chk("zero_rd", bus.rd, 64'h0);
    chk("zero_rbusy", bus.rbusy, 2'b00);
    chk("zero_cnt", bus.pending_cnt, 6'd0);

    // Fill regs 1..31
    for (int i = 1; i < DEPTH; i++) begin
      bus.we = 1'b1; bus.wa = ADDR_W'(i); bus.wd = 32'h4141_4140 + 32'(i);
      step();
    end
    for (int i = 1; i < DEPTH; i++) begin
      e = 32'h4141_4140 + 32'(i);
      setra(ADDR_W'(i), ADDR_W'(i));
      #1;
      chk("fill_same_p0", bus.rd[31:0], e);
      chk("fill_same_p1", bus.rd[63:32], e);
      setra(ADDR_W'(i), ADDR_W'((i % 31) + 1));
      #1;
      chk("fill_dist_p0", bus.rd[31:0], e);
      chk("fill_dist_p1", bus.rd[63:32], 32'h4141_4140 + 32'((i % 31) + 1));
    end

    // Same-cycle read/write on reg 5
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hAAAA_5555;
    step();
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h1111_2222;
    setra(5'd5, 5'd1);
    #1;
`ifdef REG_FILE_SB_BYPASS_EN
    chk("rw_before", bus.rd[31:0], 32'h1111_2222);
`else
    chk("rw_before", bus.rd[31:0], 32'hAAAA_5555);
`endif
    chk("rw_before_busy", bus.rbusy[0], 1'b0);
    step();
    #1;
    chk("rw_after", bus.rd[31:0], 32'h1111_2222);

    // Scoreboard: alloc 3, 7, 9
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd3; step();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd7; step();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd9; step();
    chk("sb_cnt3", bus.pending_cnt, 6'd3);
    setra(5'd3, 5'd7);
    #1;
    chk("sb_busy_3_7", bus.rbusy, 2'b11);
    setra(5'd9, 5'd4);
    #1;
    chk("sb_busy_9_4", bus.rbusy, 2'b01);

    // Write 7 clears it
    bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h0000_0077;
    step();
    chk("sb_wr7_cnt", bus.pending_cnt, 6'd2);
    setra(5'd7, 5'd3);
    #1;
    chk("sb_wr7_busy", bus.rbusy, 2'b10);

    // Alloc 3 + write 3 together: alloc wins, data still written
    bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h0000_0033;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd3;
    step();
    setra(5'd3, 5'd3);
    #1;
    chk("sb_tie_busy", bus.rbusy[0], 1'b1);
    chk("sb_tie_cnt", bus.pending_cnt, 6'd2);
    chk("sb_tie_data", bus.rd[31:0], 32'h0000_0033);

    // Alloc 12 + write 9: net zero
    bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h0000_0099;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd12;
    step();
    chk("sb_swap_cnt", bus.pending_cnt, 6'd2);
    setra(5'd12, 5'd9);
    #1;
    chk("sb_swap_busy", bus.rbusy, 2'b01);

    // Re-alloc an already busy register: count must not move
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd12;
    step();
    chk("sb_realloc_cnt", bus.pending_cnt, 6'd2);

    // Flush with same-cycle alloc 4 and write 4
    bus.flush = 1'b1;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd4;
    bus.we = 1'b1; bus.wa = 5'd4; bus.wd = 32'h0000_0005;
    step();
    chk("fl_cnt", bus.pending_cnt, 6'd0);
    setra(5'd12, 5'd3);
    #1;
    chk("fl_busy_12_3", bus.rbusy, 2'b00);
    setra(5'd4, 5'd4);
    #1;
    chk("fl_busy_4", bus.rbusy, 2'b00);
    chk("fl_data_4", bus.rd, {32'h0000_0005, 32'h0000_0005});

    // Gating: we low must not write nor clear busy
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd9;
    step();
    chk("gate_cnt_pre", bus.pending_cnt, 6'd1);
    bus.we = 1'b0; bus.wa = 5'd9; bus.wd = 32'hFACE_FACE;
    step();
    setra(5'd9, 5'd9);
    #1;
    chk("gate_data", bus.rd[31:0], 32'h0000_0099);
    chk("gate_busy", bus.rbusy, 2'b11);
    chk("gate_cnt", bus.pending_cnt, 6'd1);

    // Write to a non-busy register leaves the count alone
    bus.we = 1'b1; bus.wa = 5'd20; bus.wd = 32'h0000_2020;
    step();
    chk("idle_wr_cnt", bus.pending_cnt, 6'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 2-read/1-write register file.
- Configurable data width, register count and read-port count, with an optional hardwired-zero register 0.
- Adds a per-register busy scoreboard: issue marks a destination pending, writeback clears it.
- Sits between decode/issue (reads, allocates) and writeback (writes) of the pipelined core.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), address width (derived).
- NUM_RD, 2, number of read ports, 1 to 4.
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- we  in  1  writeback enable.
- wa  in  ADDR_W  writeback address.
- wd  in  DATA_W  writeback data.
- ra  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  packed read data; port k at [k*DATA_W +: DATA_W].
- rbusy  out  NUM_RD  bit k = busy bit of register ra[k].
- alloc_en  in  1  mark register busy (destination issued).
- alloc_addr  in  ADDR_W  register to mark busy.
- flush  in  1  clear all busy bits (pipeline squash).
- pending_cnt  out  $clog2(DEPTH+1)  number of busy registers.

Behaviour:
- Reset (async, immediate):
  - all registers = 0, all busy bits = 0, pending_cnt = 0.
  - rd and rbusy therefore read 0 for every address while rst is high and after release.
- Read path:
  - combinational, zero latency, from registered state.
  - Without bypass, a write in the same cycle is not visible until after the edge; rd shows the old value before the edge.
- Write:
  - on posedge with we = 1, reg[wa] <= wd and busy[wa] <= 0.
  - If ZERO_REG = 1 and wa = 0, the write is ignored.
- Allocate:
  - on posedge with alloc_en = 1, busy[alloc_addr] <= 1.
  - Ignored when ZERO_REG = 1 and alloc_addr = 0.
- Alloc and write to the same address in the same cycle:
  - alloc wins (new producer); busy stays 1.
  - The data write still occurs.
- Flush:
  - on posedge, all busy bits <= 0 and pending_cnt <= 0.
  - Flush dominates a same-cycle alloc; the alloc is dropped.
  - A same-cycle data write still occurs.
- pending_cnt:
  - registered and updated incrementally; must always equal the popcount of the busy bits.
  - +1 when alloc targets a non-busy register.
  - -1 when a write clears a busy register not simultaneously allocated.
  - Net 0 when both events occur on different addresses.
  - Never wraps: range 0 to DEPTH (DEPTH-1 when ZERO_REG = 1).
- Multiple read ports may address the same register; each returns identical data and busy.
- Reset asserted mid-operation clears everything immediately; stimulus on the release edge is accepted normally.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Defined (write-through forwarding): for each port k, if we = 1 and wa == ra[k], with wa != 0 when ZERO_REG = 1:
  - rd[k] = wd in the same cycle.
  - rbusy[k] = 1 only if alloc_en = 1 and alloc_addr == wa and flush = 0; otherwise 0.
- Not defined: pure registered reads as described above; no forwarding logic is synthesised.

Test Plan:
- Reset and zero register:
  - Stimulus: assert rst mid-run; then write 0xDEADBEEF to reg 0 with alloc of reg 0.
  - Required: rd = 0 and rbusy = 0 on all ports; reg 0 still reads 0, not busy; pending_cnt = 0.
- Fill and read back:
  - Stimulus: write 0x41414140+i to regs 1..31; read with all NUM_RD ports on distinct and on identical addresses.
  - Required: every port returns 0x41414140+i.
- Same-cycle read/write:
  - Stimulus: reg 5 = 0xAAAA5555; drive we, wa = 5, wd = 0x11112222, ra[0] = 5.
  - Required without bypass: 0xAAAA5555 before the edge, 0x11112222 after.
  - Required with bypass: 0x11112222 before the edge.
- Scoreboard:
  - Stimulus: alloc 3, 7, 9.
  - Required: pending_cnt = 3, rbusy set on those addresses.
  - Stimulus: write 7.
  - Required: pending_cnt = 2.
  - Stimulus: alloc 3 and write 3 together.
  - Required: busy[3] stays 1, pending_cnt = 2.
  - Stimulus: alloc 12 and write 9 together.
  - Required: pending_cnt stays 2.
- Flush:
  - Stimulus: with 2 busy, assert flush with alloc 4 and write reg 4 = 0x5 in the same cycle.
  - Required: pending_cnt = 0, rbusy all 0, reg 4 = 0x5.
- Gating:
  - Stimulus: we = 0 with wa = 9, wd = 0xFACEFACE.
  - Required: reg 9 unchanged, busy unchanged.
